// File: rtl/prio_arbiter.sv
// Fixed-priority arbiter with a bounded hold time and a one-cycle gap after every release.
// Optional round-robin search order is enabled by defining PRIO_ARBITER_ROUND_ROBIN_EN.
module prio_arbiter #(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld,
    output logic             hold_expired
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             vld_q, vld_d;
    logic             exp_q, exp_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;

`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    // Search rr_ptr-1 downward with wrap; later (smaller k) hits override earlier ones.
    // IDX_W-bit subtraction gives the modulo-N_REQ wrap since N_REQ == 2**IDX_W.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            cand = rr_ptr_q - IDX_W'(k);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req[i]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        vld_d      = vld_q;
        exp_d      = 1'b0;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        case (state_q)
            ST_BUSY: begin
                if (!req[idx_q] || (hold_cnt_q == 8'(MAX_HOLD))) begin
                    // An owner dropping on the limit cycle counts as a normal release.
                    state_d    = ST_GAP;
                    hold_cnt_d = '0;
                    gnt_d      = '0;
                    idx_d      = '0;
                    vld_d      = 1'b0;
                    exp_d      = req[idx_q];
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                if (win_found) begin
                    state_d    = ST_BUSY;
                    hold_cnt_d = 8'd1;
                    gnt_d      = N_REQ'(1) << win_idx;
                    idx_d      = win_idx;
                    vld_d      = 1'b1;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
                    rr_ptr_d   = win_idx;
`endif
                end else begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                    gnt_d      = '0;
                    idx_d      = '0;
                    vld_d      = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            idx_q      <= '0;
            vld_q      <= 1'b0;
            exp_q      <= 1'b0;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            vld_q      <= vld_d;
            exp_q      <= exp_d;
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign gnt          = gnt_q;
    assign gnt_idx      = idx_q;
    assign gnt_vld      = vld_q;
    assign hold_expired = exp_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed and randomised self-checking bench for prio_arbiter (default parameters).
module tb_prio_arbiter;

    localparam int N_REQ    = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;

    logic             clk;
    logic             rst_n;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_vld;
    logic             hold_expired;

    int n_checks;
    int n_fail;

    prio_arbiter #(
        .N_REQ   (N_REQ),
        .IDX_W   (IDX_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .gnt         (gnt),
        .gnt_idx     (gnt_idx),
        .gnt_vld     (gnt_vld),
        .hold_expired(hold_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_grant(input string tag, input logic [7:0] g, input logic [2:0] i, input logic v);
        check({tag, "_gnt"}, 32'(gnt), 32'(g));
        check({tag, "_idx"}, 32'(gnt_idx), 32'(i));
        check({tag, "_vld"}, 32'(gnt_vld), 32'(v));
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] prev_req;
        logic       prev_vld;
        logic [2:0] prev_idx;
        logic [2:0] exp_order [9];

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = '0;

        // Asynchronous reset state before any clock edge
        #2;
        check_grant("rst", 8'h00, 3'd0, 1'b0);
        check("rst_exp", 32'(hold_expired), 32'd0);
        check("rst_hold", 32'(dut.hold_cnt_q), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_grant("idle", 8'h00, 3'd0, 1'b0);

        // Highest set bit wins
        do_reset();
        req = 8'b0100_1100;
        tick();
        check_grant("prio6", 8'b0100_0000, 3'd6, 1'b1);
        check("prio6_hold", 32'(dut.hold_cnt_q), 32'd1);

        // Release after 4 cycles, gap, then next winner; higher requester cannot preempt
        do_reset();
        req = 8'b0000_1011;
        tick();
        check_grant("own3_c1", 8'b0000_1000, 3'd3, 1'b1);
        tick();
        check("own3_c2_hold", 32'(dut.hold_cnt_q), 32'd2);
        req = 8'b1000_1011;
        tick();
        check_grant("nopreempt", 8'b0000_1000, 3'd3, 1'b1);
        tick();
        check("own3_c4_hold", 32'(dut.hold_cnt_q), 32'd4);
        req = 8'b0000_0011;
        tick();
        check_grant("gap1", 8'h00, 3'd0, 1'b0);
        check("gap1_exp", 32'(hold_expired), 32'd0);
        check("gap1_hold", 32'(dut.hold_cnt_q), 32'd0);
        tick();
        check_grant("own1", 8'b0000_0010, 3'd1, 1'b1);

        // Forced release at MAX_HOLD
        do_reset();
        req = 8'b0000_0001;
        for (int i = 0; i < MAX_HOLD; i++) begin
            tick();
            check("hold_vld", 32'(gnt_vld), 32'd1);
            check("hold_noexp", 32'(hold_expired), 32'd0);
        end
        tick();
        check_grant("expgap", 8'h00, 3'd0, 1'b0);
        check("expgap_exp", 32'(hold_expired), 32'd1);
        tick();
        check_grant("regrant0", 8'b0000_0001, 3'd0, 1'b1);
        check("regrant0_exp", 32'(hold_expired), 32'd0);

        // Owner drops exactly at the limit: normal release, no expiry pulse
        for (int i = 1; i < MAX_HOLD; i++) tick();
        check("limit_hold", 32'(dut.hold_cnt_q), 32'(MAX_HOLD));
        req = 8'h00;
        tick();
        check_grant("limitrel", 8'h00, 3'd0, 1'b0);
        check("limitrel_exp", 32'(hold_expired), 32'd0);
        tick();
        check_grant("limit_idle", 8'h00, 3'd0, 1'b0);

        // All requesting, owner releases for one cycle each turn
`ifdef PRIO_ARBITER_ROUND_ROBIN_EN
        exp_order = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
        exp_order = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
        do_reset();
        req = 8'hFF;
        tick();
        for (int n = 0; n < 9; n++) begin
            check("order_idx", 32'(gnt_idx), 32'(exp_order[n]));
            check("order_vld", 32'(gnt_vld), 32'd1);
            r = 8'hFF;
            r[exp_order[n]] = 1'b0;
            req = r;
            tick();
            check("order_gap", 32'(gnt_vld), 32'd0);
            req = 8'hFF;
            tick();
        end

        // Reset between edges drops the grant immediately
        do_reset();
        req = 8'b0001_0000;
        tick();
        check_grant("pre_rst", 8'b0001_0000, 3'd4, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_grant("mid_rst", 8'h00, 3'd0, 1'b0);
        check("mid_rst_state", 32'(dut.state_q), 32'd0);
        check("mid_rst_hold", 32'(dut.hold_cnt_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_grant("post_rst", 8'b0001_0000, 3'd4, 1'b1);
        check("post_rst_hold", 32'(dut.hold_cnt_q), 32'd1);

        // Randomised invariants
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            prev_vld = gnt_vld;
            prev_idx = gnt_idx;
            r = 8'($urandom);
            if (c % 3 != 0) r = r | 8'($urandom);
            prev_req = r;
            req = r;
            tick();
            check("rnd_onehot", 32'($onehot0(gnt)), 32'd1);
            check("rnd_vld_or", 32'(gnt_vld), 32'(|gnt));
            check("rnd_holdmax", 32'(dut.hold_cnt_q <= 8'(MAX_HOLD)), 32'd1);
            if (!prev_vld && gnt_vld)
                check("rnd_gnt_req", 32'(prev_req[gnt_idx]), 32'd1);
            if (prev_vld && !prev_req[prev_idx])
                check("rnd_gap", 32'(gnt_vld), 32'd0);
            if (prev_vld && gnt_vld)
                check("rnd_hold_idx", 32'(gnt_idx), 32'(prev_idx));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
